// File: rtl/cdb_arbiter.sv
// Writeback arbiter: picks one completed FU result per cycle (round-robin) onto the CDB.
// Latency: one cycle from grant (fu_ready) to cdb_valid; one result per cycle sustained.
// Backpressure: cdb_ready low with cdb_valid high holds the output register and ptr, and fu_ready stays 0.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   fu_valid/fu_tag/fu_data/fu_exc  per-FU result request, FU i at [i*W +: W]
//   fu_ready                     one-hot grant, combinational
//   flush                        drops the CDB slot and blocks grants this cycle
//   cdb_ready                    ROB consumes the CDB this cycle
//   cdb_valid/tag/data/exc/fu    registered CDB result and source FU index
//   stall_cnt                    (only with CDB_ARB_STALL_CNT_EN) saturating stall-cycle count
// Optional feature macro: CDB_ARB_STALL_CNT_EN
module cdb_arbiter #(
  parameter int NUM_FU = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  localparam int FU_W  = $clog2(NUM_FU)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_FU-1:0]          fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]    fu_tag,
  input  logic [NUM_FU*DATA_W-1:0]   fu_data,
  input  logic [NUM_FU-1:0]          fu_exc,
  output logic [NUM_FU-1:0]          fu_ready,
  input  logic                       flush,
  input  logic                       cdb_ready,
  output logic                       cdb_valid,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [DATA_W-1:0]          cdb_data,
  output logic                       cdb_exc,
  output logic [FU_W-1:0]            cdb_fu
`ifdef CDB_ARB_STALL_CNT_EN
  ,
  output logic [15:0]                stall_cnt
`endif
);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              exc;
    logic [FU_W-1:0]   fu;
  } cdb_t;

  localparam logic [FU_W:0] NUM_FU_W = (FU_W+1)'(NUM_FU);

  logic [FU_W-1:0]   ptr;
  logic [FU_W-1:0]   off;
  logic [FU_W-1:0]   win;
  logic [FU_W-1:0]   ptr_nxt;
  logic [FU_W:0]     sum;
  logic [NUM_FU-1:0] rot;
  logic              found;
  logic              slot_free;
  logic              grant;
  logic              cdb_vld_q;
  cdb_t              sel;
  cdb_t              cdb_q;

  assign slot_free = !cdb_vld_q | cdb_ready;

  // Rotate requests so bit 0 is the FU at ptr; the lowest set bit is the winner offset.
  assign rot = NUM_FU'({fu_valid, fu_valid} >> ptr);

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = FU_W'(k);
      end
    end
    // ptr + off modulo NUM_FU; works for non-power-of-two NUM_FU too.
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NUM_FU_W) begin
      sum = sum - NUM_FU_W;
    end
    win = sum[FU_W-1:0];
  end

  assign ptr_nxt = (win == FU_W'(NUM_FU - 1)) ? '0 : win + FU_W'(1);

  // rst_n is in the grant term so fu_ready is 0 throughout reset.
  assign grant    = rst_n & slot_free & !flush & found;
  assign fu_ready = grant ? (NUM_FU'(1) << win) : '0;

  always_comb begin
    sel    = '0;
    sel.fu = win;
    for (int i = 0; i < NUM_FU; i++) begin
      if (win == FU_W'(i)) begin
        sel.tag  = fu_tag[i*TAG_W +: TAG_W];
        sel.data = fu_data[i*DATA_W +: DATA_W];
        sel.exc  = fu_exc[i];
      end
    end
  end

  // Payload fields are left stale when the slot empties; only valid and ptr matter then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_vld_q <= 1'b0;
      cdb_q     <= '0;
      ptr       <= '0;
    end else if (grant) begin
      cdb_vld_q <= 1'b1;
      cdb_q     <= sel;
      ptr       <= ptr_nxt;
    end else if (slot_free || flush) begin
      cdb_vld_q <= 1'b0;
    end
  end

  assign cdb_valid = cdb_vld_q;
  assign cdb_tag   = cdb_q.tag;
  assign cdb_data  = cdb_q.data;
  assign cdb_exc   = cdb_q.exc;
  assign cdb_fu    = cdb_q.fu;

`ifdef CDB_ARB_STALL_CNT_EN
  // Counts cycles a result sits on the CDB unconsumed; survives flush, saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (cdb_vld_q && !cdb_ready && !flush && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  logic        clk;
  logic        rst_n;
  logic [3:0]  fu_valid;
  logic [15:0] fu_tag;
  logic [127:0] fu_data;
  logic [3:0]  fu_exc;
  logic [3:0]  fu_ready;
  logic        flush;
  logic        cdb_ready;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        cdb_exc;
  logic [1:0]  cdb_fu;
`ifdef CDB_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  cdb_arbiter #(.NUM_FU(4), .TAG_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_data(fu_data), .fu_exc(fu_exc),
    .fu_ready(fu_ready), .flush(flush), .cdb_ready(cdb_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_exc(cdb_exc), .cdb_fu(cdb_fu)
`ifdef CDB_ARB_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int exp_g[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n     = 1'b0;
    fu_valid  = 4'b1111;
    fu_exc    = 4'b1001;
    flush     = 1'b0;
    cdb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fu_tag[i*4 +: 4]   = 4'(8 + i);
      fu_data[i*32 +: 32] = 32'h1000_0000 + 32'(i);
    end

    // Reset held with all FUs requesting.
    #12;
    chk("rst_fu_ready", 64'(fu_ready), 64'h0);
    chk("rst_cdb_valid", 64'(cdb_valid), 64'h0);
    chk("rst_cdb_tag", 64'(cdb_tag), 64'h0);
    chk("rst_cdb_data", 64'(cdb_data), 64'h0);
    chk("rst_cdb_fu", 64'(cdb_fu), 64'h0);
    chk("rst_cdb_exc", 64'(cdb_exc), 64'h0);
    cyc();
    rst_n = 1'b1;
    #1;

    // Round-robin over all four FUs, then wrap to FU0.
    for (int i = 0; i < 5; i++) begin
      chk("rr_grant", 64'(fu_ready), 64'(4'b0001 << exp_g[i]));
      cyc();
      chk("rr_cdb_valid", 64'(cdb_valid), 64'h1);
      chk("rr_cdb_fu", 64'(cdb_fu), 64'(exp_g[i]));
      chk("rr_cdb_tag", 64'(cdb_tag), 64'(8 + exp_g[i]));
      chk("rr_cdb_data", 64'(cdb_data), 64'(32'h1000_0000 + 32'(exp_g[i])));
      chk("rr_cdb_exc", 64'(cdb_exc), 64'(fu_exc[exp_g[i]]));
      #1;
    end

    // ptr=1: only FU2 valid -> FU2, ptr=3.
    fu_valid = 4'b0100;
    #1 chk("skip_grant2", 64'(fu_ready), 64'h4);
    cyc();
    chk("skip_cdb_fu2", 64'(cdb_fu), 64'h2);
    // ptr=3, 0101 -> wrap to FU0, ptr=1; then FU2, ptr=3.
    fu_valid = 4'b0101;
    #1 chk("wrap_grant0", 64'(fu_ready), 64'h1);
    cyc();
    chk("wrap_cdb_fu0", 64'(cdb_fu), 64'h0);
    #1 chk("wrap_grant2", 64'(fu_ready), 64'h4);
    cyc();
    chk("wrap_cdb_fu2", 64'(cdb_fu), 64'h2);

    // ptr=3, only FU1 valid with tag 5 / DEADBEEF -> FU1, ptr=2.
    fu_tag[4 +: 4]   = 4'd5;
    fu_data[32 +: 32] = 32'hDEADBEEF;
    fu_valid = 4'b0010;
    #1 chk("bp_load_grant", 64'(fu_ready), 64'h2);
    cyc();
    chk("bp_load_tag", 64'(cdb_tag), 64'h5);
    chk("bp_load_data", 64'(cdb_data), 64'hDEADBEEF);

    // Backpressure for 3 cycles with everyone requesting.
    cdb_ready = 1'b0;
    fu_valid  = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_no_grant", 64'(fu_ready), 64'h0);
      cyc();
      chk("bp_hold_valid", 64'(cdb_valid), 64'h1);
      chk("bp_hold_tag", 64'(cdb_tag), 64'h5);
      chk("bp_hold_data", 64'(cdb_data), 64'hDEADBEEF);
      chk("bp_hold_fu", 64'(cdb_fu), 64'h1);
    end
`ifdef CDB_ARB_STALL_CNT_EN
    chk("bp_stall_cnt", 64'(stall_cnt), 64'h3);
`endif
    // Ready returns: grant in the same cycle, ptr=2 -> FU2, ptr=3.
    cdb_ready = 1'b1;
    #1 chk("bp_release_grant", 64'(fu_ready), 64'h4);
    cyc();
    chk("bp_release_fu", 64'(cdb_fu), 64'h2);
    chk("bp_release_tag", 64'(cdb_tag), 64'hA);

    // Flush while CDB valid and FU1 requesting.
    fu_valid = 4'b0010;
    flush    = 1'b1;
    #1 chk("fl_no_grant", 64'(fu_ready), 64'h0);
    cyc();
    chk("fl_cdb_valid", 64'(cdb_valid), 64'h0);
    flush = 1'b0;
    #1 chk("fl_after_grant1", 64'(fu_ready), 64'h2);
    cyc();
    chk("fl_after_valid", 64'(cdb_valid), 64'h1);
    chk("fl_after_fu", 64'(cdb_fu), 64'h1);
    // ptr=2 now; flush must not move it, so FU2 wins afterwards.
    fu_valid = 4'b1111;
    flush    = 1'b1;
    #1 chk("fl2_no_grant", 64'(fu_ready), 64'h0);
    cyc();
    chk("fl2_cdb_valid", 64'(cdb_valid), 64'h0);
    flush = 1'b0;
    #1 chk("fl2_ptr_kept", 64'(fu_ready), 64'h4);
    cyc();
    chk("fl2_cdb_fu", 64'(cdb_fu), 64'h2);

    // Idle with free slot clears cdb_valid.
    fu_valid = 4'b0000;
    #1 chk("idle_no_grant", 64'(fu_ready), 64'h0);
    cyc();
    chk("idle_cdb_valid", 64'(cdb_valid), 64'h0);

    // Load FU0 (exc=1), ptr -> 1, then async reset mid-cycle.
    fu_valid = 4'b0001;
    #1 chk("mr_grant0", 64'(fu_ready), 64'h1);
    cyc();
    chk("mr_pre_valid", 64'(cdb_valid), 64'h1);
    chk("mr_pre_exc", 64'(cdb_exc), 64'h1);
    fu_valid = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", 64'(cdb_valid), 64'h0);
    chk("mr_tag", 64'(cdb_tag), 64'h0);
    chk("mr_data", 64'(cdb_data), 64'h0);
    chk("mr_exc", 64'(cdb_exc), 64'h0);
    chk("mr_fu", 64'(cdb_fu), 64'h0);
    chk("mr_fu_ready", 64'(fu_ready), 64'h0);
    cyc();
    rst_n = 1'b1;
    #1 chk("mr_ptr_zero", 64'(fu_ready), 64'h1);
    cyc();
    chk("mr_post_fu", 64'(cdb_fu), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

- Writeback arbiter between the execution functional units (FUs) and the reorder buffer.
- Each cycle it selects at most one completed FU result, using rotating (round-robin) priority, and registers it onto the common data bus (CDB).
- The ROB reads the CDB to mark its entries complete.
- Provides valid/ready backpressure on both sides, a flush that drops in-flight results, and a bounded-starvation guarantee.

## Interface
- NUM_FU, 4, number of requesting FUs (≥2)
- TAG_W, 4, ROB index width
- DATA_W, 32, result width
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- fu_valid  input  NUM_FU  per-FU result valid
- fu_tag  input  NUM_FU*TAG_W  per-FU ROB tag, FU i at bits [i*TAG_W +: TAG_W]
- fu_data  input  NUM_FU*DATA_W  per-FU result, same packing
- fu_exc  input  NUM_FU  per-FU exception flag
- fu_ready  output  NUM_FU  one-hot grant; transfer on fu_valid[i] & fu_ready[i]
- flush  input  1  mispredict/exception flush from ROB
- cdb_ready  input  1  ROB accepts CDB this cycle
- cdb_valid  output  1  CDB holds a result
- cdb_tag  output  TAG_W  ROB tag of result
- cdb_data  output  DATA_W  result value
- cdb_exc  output  1  exception flag
- cdb_fu  output  $clog2(NUM_FU)  index of source FU

## Operation
- **Output register.** A single register holds {valid, tag, data, exc, fu}.
- **Slot free.** The slot is free when !cdb_valid | cdb_ready.
- **Grant.** When the slot is free and flush=0:
  - Search fu_valid from index ptr upward, wrapping NUM_FU-1→0.
  - The first valid index w gets fu_ready[w]=1; all other fu_ready bits are 0.
  - w's tag, data and exc load into the output register at the next edge, with cdb_fu=w.
- **No grant.** If the slot is not free, or no fu_valid is set, fu_ready=0.
  - If the slot is free and nothing is granted, cdb_valid clears at the next edge.
- **Pointer.** ptr ← (w+1) mod NUM_FU on every grant. Otherwise ptr holds.
- **Starvation bound.** A continuously valid FU is granted within NUM_FU grants.
- **Combinational path.** fu_ready is combinational from fu_valid, ptr, cdb_valid, cdb_ready, flush and rst_n.
- **FU rule.** Once asserted, fu_valid[i] and its tag/data/exc hold stable until the transfer. The arbiter does not check this.
- **Flush.**
  - In a flush cycle, fu_ready=0.
  - At the next edge cdb_valid←0; ptr is unchanged.
  - A CDB handshake in a flush cycle is not a transfer, and the ROB discards it.
  - FUs drop their own results on flush. The arbiter holds no other pending state.
- **Backpressure.** With cdb_valid=1 and cdb_ready=0, the output register and ptr hold and fu_ready=0.

## Timing
- Reset values (rst_n low, applied asynchronously):
  - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_exc=0, cdb_fu=0, ptr=0.
  - fu_ready=0 while rst_n=0.
- Latency is one cycle: a grant in cycle n gives cdb_valid=1 in cycle n+1.
- Throughput is one result per cycle when cdb_ready stays high.
- Back-to-back: a grant may occur in the same cycle as a CDB transfer (slot free via cdb_ready).
- Reset asserted mid-operation: the held result is lost with no partial output, and ptr returns to 0.
- Only cdb_valid and ptr are significant after flush. The tag/data/exc/fu fields keep stale values.

## Configuration
- Macro: CDB_ARB_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt, 16 bits.
  - stall_cnt increments each cycle with cdb_valid & !cdb_ready & !flush.
  - It saturates at 16'hFFFF and resets to 0 on rst_n.
  - It is not cleared by flush.
- Undefined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- **Reset.** Hold rst_n=0 with fu_valid=4'b1111 → fu_ready=0 and cdb_valid=0.
  - Release reset → first grant goes to FU0 and ptr becomes 1.
- **Round-robin.** fu_valid=4'b1111 held, cdb_ready=1 → grant order 0,1,2,3,0 over 5 cycles.
  - cdb_fu follows one cycle later, with the matching tags.
- **Wrap and skip.** ptr=3, fu_valid=4'b0101 → FU0 granted, ptr=1.
  - Next grant is FU2, ptr=3.
- **Backpressure.** Hold cdb_ready=0 for 3 cycles with cdb_valid=1, tag=5, data=32'hDEADBEEF.
  - Outputs stay stable and fu_ready=0.
  - stall_cnt=3 with CDB_ARB_STALL_CNT_EN.
  - When cdb_ready rises, a new grant occurs the same cycle.
- **Flush collision.** Assert flush with fu_valid=4'b0010 and cdb_valid=1.
  - fu_ready=0 that cycle; cdb_valid=0 next cycle; ptr is unchanged.
  - With FU1 still valid, FU1 is granted in the cycle after flush.
- **Reset mid-transfer.** Drop rst_n asynchronously mid-cycle while cdb_valid=1.
  - cdb_valid falls immediately, without waiting for a clock edge, and all outputs read 0.
